// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// Reason codes, scoreboard geometry and counter limits.
package pipe_ctrl_pkg;

    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_FULL = '1;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_RAW   = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sb.sv
// Per-register write scoreboard with 2-bit in-flight counters.
// PIPE_CTRL_WB_BYPASS_EN: a retiring write no longer counts as pending.
module pipe_ctrl_sb
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic [4:0] inc_rd_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    output logic       pend1_o,
    output logic       pend2_o,
    output logic       full_o
);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;
    logic [NREG-1:0]  pend_v;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = inc_i && (inc_rd_i == 5'(r)) && (r != 0);
            dec_v[r] = wb_we_i && (wb_rd_i == 5'(r)) && (r != 0)
                       && (cnt_q[r] != 2'd0);
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec_v[r] && !inc_v[r]) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
`ifdef PIPE_CTRL_WB_BYPASS_EN
            pend_v[r] = (cnt_q[r] > 2'd1)
                        || ((cnt_q[r] == 2'd1)
                            && !(wb_we_i && (wb_rd_i == 5'(r))));
`else
            pend_v[r] = (cnt_q[r] != 2'd0);
`endif
        end
        // x0 is hardwired, never a hazard source
        pend_v[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign pend1_o = pend_v[rs1_i];
    assign pend2_o = pend_v[rs2_i];
    assign full_o  = (rd_i != 5'd0) && (cnt_q[rd_i] == CNT_FULL);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: MEM > FLUSH > RAW > RUN priority.
// Optional write-through bypass via PIPE_CTRL_WB_BYPASS_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_reg1_RE_i,
    input  logic        id_reg2_RE_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_reg_we_i,
    input  logic        ex_jump_i,
    input  logic        mem_busy_i,
    input  logic        wb_reg_we_i,
    input  logic [4:0]  wb_rd_addr_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        ex_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        issue_o,
    output logic [1:0]  ctrl_state_o,
    output logic [15:0] stall_cnt_o
);

    ctrl_state_e state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        pend1, pend2, full, raw;

    pipe_ctrl_sb u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (issue_o && id_reg_we_i),
        .inc_rd_i (id_rd_addr_i),
        .wb_we_i  (wb_reg_we_i),
        .wb_rd_i  (wb_rd_addr_i),
        .rs1_i    (id_rs1_addr_i),
        .rs2_i    (id_rs2_addr_i),
        .rd_i     (id_rd_addr_i),
        .pend1_o  (pend1),
        .pend2_o  (pend2),
        .full_o   (full)
    );

    assign raw = id_valid_i && (
        (id_reg1_RE_i && (id_rs1_addr_i != 5'd0) && pend1)
        || (id_reg2_RE_i && (id_rs2_addr_i != 5'd0) && pend2)
        || (id_reg_we_i && full));

    always_comb begin
        state_d       = ST_RUN;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        ex_stall_o    = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        issue_o       = 1'b0;
        if (!rst_n) begin
            state_d = ST_RUN;
        end else if (mem_busy_i) begin
            // a pending jump stays asserted while EX is frozen
            state_d       = ST_MEM;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            ex_stall_o    = 1'b1;
        end else if (ex_jump_i) begin
            state_d       = ST_FLUSH;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (raw) begin
            state_d       = ST_RAW;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else begin
            state_d = ST_RUN;
            issue_o = id_valid_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_d != ST_RUN) && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_state_o = state_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector scoreboard bench for pipe_ctrl.
// Expectations adapt when PIPE_CTRL_WB_BYPASS_EN is defined.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_reg1_RE_i, id_reg2_RE_i, id_reg_we_i;
    logic        ex_jump_i, mem_busy_i, wb_reg_we_i;
    logic [4:0]  wb_rd_addr_i;
    logic        pc_stall_o, if_id_stall_o, ex_stall_o;
    logic        if_id_flush_o, id_ex_flush_o, issue_o;
    logic [1:0]  ctrl_state_o;
    logic [15:0] stall_cnt_o;

    typedef struct {
        logic [5:0]  o;
        logic [1:0]  st;
        logic [15:0] sc;
        string       nm;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   passed = 0;

    // outputs packed as {pc, ifid, ex, ifid_flush, idex_flush, issue}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_ISS  = 6'b000001;
    localparam logic [5:0] O_RAW  = 6'b110010;
    localparam logic [5:0] O_MEM  = 6'b111000;
    localparam logic [5:0] O_FL   = 6'b000110;

`ifdef PIPE_CTRL_WB_BYPASS_EN
    localparam int SC = 2;
`else
    localparam int SC = 3;
`endif

    pipe_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_reg1_RE_i  (id_reg1_RE_i),
        .id_reg2_RE_i  (id_reg2_RE_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_reg_we_i   (id_reg_we_i),
        .ex_jump_i     (ex_jump_i),
        .mem_busy_i    (mem_busy_i),
        .wb_reg_we_i   (wb_reg_we_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .pc_stall_o    (pc_stall_o),
        .if_id_stall_o (if_id_stall_o),
        .ex_stall_o    (ex_stall_o),
        .if_id_flush_o (if_id_flush_o),
        .id_ex_flush_o (id_ex_flush_o),
        .issue_o       (issue_o),
        .ctrl_state_o  (ctrl_state_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            automatic logic [5:0] act = {pc_stall_o, if_id_stall_o,
                ex_stall_o, if_id_flush_o, id_ex_flush_o, issue_o};
            total++;
            if (act === e.o && ctrl_state_o === e.st
                && stall_cnt_o === e.sc) begin
                passed++;
            end else begin
                $display("FAIL %s: got outs=%b st=%0d sc=%0d, want outs=%b st=%0d sc=%0d",
                         e.nm, act, ctrl_state_o, stall_cnt_o,
                         e.o, e.st, e.sc);
            end
        end
    end

    task automatic step(
        input logic       rst,
        input logic       v,
        input logic [4:0] rs1,
        input logic       re1,
        input logic [4:0] rs2,
        input logic       re2,
        input logic [4:0] rd,
        input logic       we,
        input logic       j,
        input logic       b,
        input logic       wbw,
        input logic [4:0] wbr,
        input logic [5:0] eo,
        input logic [1:0] est,
        input int         esc,
        input string      nm
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = rst;
        id_valid_i    = v;
        id_rs1_addr_i = rs1;
        id_reg1_RE_i  = re1;
        id_rs2_addr_i = rs2;
        id_reg2_RE_i  = re2;
        id_rd_addr_i  = rd;
        id_reg_we_i   = we;
        ex_jump_i     = j;
        mem_busy_i    = b;
        wb_reg_we_i   = wbw;
        wb_rd_addr_i  = wbr;
        e.o  = eo;
        e.st = est;
        e.sc = 16'(esc);
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid_i = 1'b0;
        id_rs1_addr_i = '0;
        id_rs2_addr_i = '0;
        id_rd_addr_i = '0;
        id_reg1_RE_i = 1'b0;
        id_reg2_RE_i = 1'b0;
        id_reg_we_i = 1'b0;
        ex_jump_i = 1'b0;
        mem_busy_i = 1'b0;
        wb_reg_we_i = 1'b0;
        wb_rd_addr_i = '0;
        repeat (2) @(posedge clk);

        // rst, v, rs1, re1, rs2, re2, rd, we, j, b, wbw, wbr
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_NONE, 0, 0, "reset_forces_zero");
        step(1, 1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, O_ISS, 0, 0, "issue_addi_x5");
        step(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, O_RAW, 0, 0, "raw_x5_c1");
        step(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, O_RAW, 1, 1, "raw_x5_c2");
`ifdef PIPE_CTRL_WB_BYPASS_EN
        step(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 5, O_ISS, 1, 2, "raw_wb_bypass_issue");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, 2, "idle_after_bypass");
`else
        step(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 5, O_RAW, 1, 2, "raw_wb_cycle_stall");
        step(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, O_ISS, 1, 3, "raw_issue_after_wb");
`endif
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, O_NONE, 0, SC, "wb_x6_idle");
        step(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, O_ISS, 0, SC, "x0_write_issue");
        step(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, O_ISS, 0, SC, "x0_read_no_stall");
        step(1, 1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, O_FL, 0, SC, "jump_flush");
        step(1, 1, 7, 1, 0, 0, 8, 0, 0, 0, 0, 0, O_ISS, 3, SC + 1, "x7_not_counted");
        step(1, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, O_MEM, 0, SC + 1, "mem_jump_c1");
        step(1, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, O_MEM, 2, SC + 2, "mem_jump_c2");
        step(1, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, O_MEM, 2, SC + 3, "mem_jump_c3");
        step(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, O_FL, 2, SC + 4, "deferred_flush");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 3, SC + 5, "after_flush");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_ISS, 0, SC + 5, "x9_issue1");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_ISS, 0, SC + 5, "x9_issue2");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_ISS, 0, SC + 5, "x9_issue3");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_RAW, 0, SC + 5, "x9_full_stall");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, O_NONE, 1, SC + 6, "x9_wb");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 9, O_ISS, 0, SC + 6, "x9_issue_and_wb");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_ISS, 0, SC + 6, "x9_refill");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, O_RAW, 0, SC + 6, "x9_full_again");
        step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, O_ISS, 1, SC + 7, "x3_issue1");
        step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, O_ISS, 0, SC + 7, "x3_issue2");
        step(1, 1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 0, O_RAW, 0, SC + 7, "x3_raw");
        step(0, 1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 0, O_NONE, 1, SC + 8, "mid_reset");
        step(1, 1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 0, O_ISS, 0, 0, "post_reset_issue");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, 0, "post_reset_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
